// File: rtl/binconv_datapath_if.sv
// -----------------------------------------------------------------------------
// binconv_datapath_if
//
// Memory-side bus of the binary-convolution datapath. It groups the input
// memory read port (activation and weight words at one shared address) and
// the output memory write port.
//
// Parameters:
//   N     - activation/weight word width in bits
//   DEPTH - entries in the input and output memories (power of two)
//   AW    - address width
//   OW    - result word width
//
// Signals:
//   rd_addr   - input-memory read address (datapath -> memory)
//   rd_en     - input-memory read strobe (datapath -> memory)
//   act_rdata - activation word, combinational read (memory -> datapath)
//   wgt_rdata - weight word, combinational read (memory -> datapath)
//   wr_addr   - output-memory write address (datapath -> memory)
//   wr_en     - output-memory write strobe (datapath -> memory)
//   wr_data   - result word to store (datapath -> memory)
//
// Modports:
//   master - the datapath side
//   slave  - the memory side
// -----------------------------------------------------------------------------
interface binconv_datapath_if #(
  parameter int N     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int OW    = $clog2(N) + 2
);

  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [N-1:0]  act_rdata;
  logic [N-1:0]  wgt_rdata;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [OW-1:0] wr_data;

  modport master (
    output rd_addr,
    output rd_en,
    input  act_rdata,
    input  wgt_rdata,
    output wr_addr,
    output wr_en,
    output wr_data
  );

  modport slave (
    input  rd_addr,
    input  rd_en,
    output act_rdata,
    output wgt_rdata,
    input  wr_addr,
    input  wr_en,
    input  wr_data
  );

endinterface

// File: rtl/binconv_datapath.sv
// -----------------------------------------------------------------------------
// binconv_datapath
//
// Datapath slave of the binary-convolution controller. Every cycle it decodes
// the controller state and performs exactly one step of a frame:
//   READMEM  -> capture activation/weight words
//   XNORS    -> bitwise XNOR of the captured pair
//   COUNT1S  -> popcount of the XNOR word
//   OUTPUTS  -> form the result word
//   WRITEMEM -> strobe the output write, then advance the write pointer
//   DONE     -> flag completion, then advance the read pointer
//   WAIT     -> hold everything
//   SYSRESET -> clear every register, same effect as reset_b low
// Steps that arrive out of order simply operate on whatever the registers
// currently hold.
//
// Build option:
//   BINCONV_SIGNED_OUT_EN defined   : result = 2*popcount - N (two's
//                                     complement, the +/-1 dot product);
//                                     thresh is ignored.
//   BINCONV_SIGNED_OUT_EN undefined : result = (popcount >= thresh), LSB only.
//
// Ports:
//   clk      in   - clock, rising edge
//   reset_b  in   - synchronous active-low reset
//   cState   in 3 - controller state code
//   thresh   in   - popcount threshold, sampled in OUTPUTS
//   mem      if   - memory bus (binconv_datapath_if.master)
//   done     out  - high while cState is DONE (combinational)
//   popcount out  - registered popcount, for debug/scoreboarding
// -----------------------------------------------------------------------------
module binconv_datapath #(
  parameter int N     = 16,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(N + 1),
  parameter int OW    = $clog2(N) + 2
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic [2:0]                cState,
  input  logic [CW-1:0]             thresh,
  binconv_datapath_if.master        mem,
  output logic                      done,
  output logic [CW-1:0]             popcount
);

  // Controller state encoding (Gray-ordered around the frame loop).
  localparam logic [2:0] ST_WAIT     = 3'b000;
  localparam logic [2:0] ST_READMEM  = 3'b001;
  localparam logic [2:0] ST_XNORS    = 3'b011;
  localparam logic [2:0] ST_COUNT1S  = 3'b010;
  localparam logic [2:0] ST_OUTPUTS  = 3'b110;
  localparam logic [2:0] ST_WRITEMEM = 3'b111;
  localparam logic [2:0] ST_DONE     = 3'b101;
  localparam logic [2:0] ST_SYSRESET = 3'b100;

  // Extended width for the bipolar result so 2*popcount and the subtraction
  // of N never overflow before the final truncation to OW bits.
  localparam int EW = OW + 2;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Number of set bits in a word; CW bits always hold 0..N.
  function automatic logic [CW-1:0] count_ones(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Pointer advance; DEPTH is a power of two so the natural AW-bit wrap
  // takes DEPTH-1 back to 0.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

`ifdef BINCONV_SIGNED_OUT_EN
  // Each matching bit contributes +1 and each mismatching bit -1, so the dot
  // product is matches - (N - matches) = 2*popcount - N, range -N..+N.
  function automatic logic signed [OW-1:0] bipolar_dot(input logic [CW-1:0] pc);
    logic signed [EW-1:0] twice;
    logic signed [EW-1:0] res;
    twice = $signed(EW'({pc, 1'b0}));
    res   = twice - $signed(EW'(N));
    return res[OW-1:0];
  endfunction
`else
  // Binary activation: a single 1 in the LSB when the match count reaches
  // the threshold.
  function automatic logic signed [OW-1:0] threshold_bit(input logic [CW-1:0] pc,
                                                         input logic [CW-1:0] th);
    return {{(OW-1){1'b0}}, (pc >= th)};
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [N-1:0]         act_p0;
  logic [N-1:0]         wgt_p0;
  logic [N-1:0]         xnor_p1;
  logic [CW-1:0]        pop_p2;
  logic signed [OW-1:0] res_p3;
  logic signed [OW-1:0] res_next;

`ifdef BINCONV_SIGNED_OUT_EN
  assign res_next = bipolar_dot(pop_p2);
  // The threshold has no role in the signed result.
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`else
  assign res_next = threshold_bit(pop_p2, thresh);
`endif

  always_ff @(posedge clk) begin
    // SYSRESET behaves exactly like the external reset so the controller can
    // restart a frame sequence without toggling reset_b.
    if (!reset_b || cState == ST_SYSRESET) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      act_p0  <= '0;
      wgt_p0  <= '0;
      xnor_p1 <= '0;
      pop_p2  <= '0;
      res_p3  <= '0;
    end else begin
      unique case (cState)
        // Stage p0: operand capture from combinational-read memory
        ST_READMEM: begin
          act_p0 <= mem.act_rdata;
          wgt_p0 <= mem.wgt_rdata;
        end
        // Stage p1: bitwise agreement of activation and weight
        ST_XNORS: begin
          xnor_p1 <= ~(act_p0 ^ wgt_p0);
        end
        // Stage p2: match count
        ST_COUNT1S: begin
          pop_p2 <= count_ones(xnor_p1);
        end
        // Stage p3: result word, held through WRITEMEM
        ST_OUTPUTS: begin
          res_p3 <= res_next;
        end
        ST_WRITEMEM: begin
          wr_ptr <= ptr_inc(wr_ptr);
        end
        ST_DONE: begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        default: begin
          // WAIT holds every register.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes decode cState directly, everything else is registered
  // ---------------------------------------------------------------------------
  assign mem.rd_en   = (cState == ST_READMEM);
  assign mem.wr_en   = (cState == ST_WRITEMEM);
  assign done        = (cState == ST_DONE);

  assign mem.rd_addr = rd_ptr;
  assign mem.wr_addr = wr_ptr;
  assign mem.wr_data = res_p3;
  assign popcount    = pop_p2;

endmodule

// File: tb/tb_binconv_datapath.sv
// -----------------------------------------------------------------------------
// tb_binconv_datapath
//
// Directed bench for binconv_datapath (N=16, DEPTH=256). Drives cState the
// way the controller would, supplies memory read data directly through the
// interface, and checks every output against hand-computed values. Expected
// result words follow the BINCONV_SIGNED_OUT_EN build option.
// -----------------------------------------------------------------------------
module tb_binconv_datapath;

  localparam int N     = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int CW    = 5;
  localparam int OW    = 6;

  localparam logic [2:0] WAIT     = 3'b000;
  localparam logic [2:0] READMEM  = 3'b001;
  localparam logic [2:0] XNORS    = 3'b011;
  localparam logic [2:0] COUNT1S  = 3'b010;
  localparam logic [2:0] OUTPUTS  = 3'b110;
  localparam logic [2:0] WRITEMEM = 3'b111;
  localparam logic [2:0] DONE     = 3'b101;
  localparam logic [2:0] SYSRESET = 3'b100;

`ifdef BINCONV_SIGNED_OUT_EN
  localparam logic [OW-1:0] WD_ALL  = 6'd16;      // pop 16 -> +16
  localparam logic [OW-1:0] WD_NONE = 6'b110000;  // pop 0  -> -16
  localparam logic [OW-1:0] WD_T15  = 6'd14;      // pop 15 -> +14
  localparam logic [OW-1:0] WD_T16  = 6'd14;      // thresh ignored
`else
  localparam logic [OW-1:0] WD_ALL  = 6'd1;       // 16 >= 8
  localparam logic [OW-1:0] WD_NONE = 6'd0;       // 0 >= 1 false
  localparam logic [OW-1:0] WD_T15  = 6'd1;       // 15 >= 15
  localparam logic [OW-1:0] WD_T16  = 6'd0;       // 15 >= 16 false
`endif

  logic          clk = 1'b0;
  logic          reset_b;
  logic [2:0]    cState;
  logic [CW-1:0] thresh;
  logic          done;
  logic [CW-1:0] popcount;

  int n_cmp = 0;
  int n_bad = 0;

  binconv_datapath_if #(.N(N), .DEPTH(DEPTH), .AW(AW), .OW(OW)) mem_if ();

  binconv_datapath #(.N(N), .DEPTH(DEPTH), .AW(AW), .CW(CW), .OW(OW)) dut (
    .clk      (clk),
    .reset_b  (reset_b),
    .cState   (cState),
    .thresh   (thresh),
    .mem      (mem_if),
    .done     (done),
    .popcount (popcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a state for one cycle; returns 1 time unit after the edge.
  task automatic step(input logic [2:0] s);
    cState = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm, input logic [AW-1:0] eaddr,
                          input logic [CW-1:0] epop, input logic [OW-1:0] ewd);
    chk({nm, ".rd_en"},    mem_if.rd_en,   0);
    chk({nm, ".wr_en"},    mem_if.wr_en,   0);
    chk({nm, ".done"},     done,           0);
    chk({nm, ".rd_addr"},  mem_if.rd_addr, eaddr);
    chk({nm, ".wr_addr"},  mem_if.wr_addr, eaddr);
    chk({nm, ".popcount"}, popcount,       epop);
    chk({nm, ".wr_data"},  mem_if.wr_data, ewd);
  endtask

  // One complete frame starting and ending at posedge+1.
  task automatic do_frame(input logic [N-1:0] a, input logic [N-1:0] w,
                          input logic [CW-1:0] th, input logic [CW-1:0] epop,
                          input logic [OW-1:0] ewd, input logic [AW-1:0] eaddr,
                          input string nm);
    logic [AW-1:0] nx;
    nx = eaddr + 8'd1;
    mem_if.act_rdata = a;
    mem_if.wgt_rdata = w;
    cState = READMEM;
    #1;
    chk({nm, ".rd_en"},   mem_if.rd_en,   1);
    chk({nm, ".rd_addr"}, mem_if.rd_addr, eaddr);
    @(posedge clk);
    #1;
    // Operands must already be captured; disturb the bus.
    mem_if.act_rdata = ~a;
    mem_if.wgt_rdata = a;
    step(XNORS);
    step(COUNT1S);
    chk({nm, ".popcount"}, popcount, epop);
    thresh = th;
    step(OUTPUTS);
    thresh = ~th;
    chk({nm, ".wr_data"}, mem_if.wr_data, ewd);
    cState = WRITEMEM;
    #1;
    chk({nm, ".wr_en"},      mem_if.wr_en,   1);
    chk({nm, ".wr_addr"},    mem_if.wr_addr, eaddr);
    chk({nm, ".wr_data_wm"}, mem_if.wr_data, ewd);
    chk({nm, ".rd_addr_wm"}, mem_if.rd_addr, eaddr);
    @(posedge clk);
    #1;
    cState = DONE;
    #1;
    chk({nm, ".done"},       done,           1);
    chk({nm, ".wr_en_dn"},   mem_if.wr_en,   0);
    chk({nm, ".wr_addr_dn"}, mem_if.wr_addr, nx);
    @(posedge clk);
    #1;
    chk({nm, ".rd_addr_nx"}, mem_if.rd_addr, nx);
    step(WAIT);
  endtask

  initial begin
    reset_b          = 1'b0;
    cState           = SYSRESET;
    thresh           = '0;
    mem_if.act_rdata = 16'h1234;
    mem_if.wgt_rdata = 16'h4321;

    // Reset with the controller in SYSRESET.
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset", 8'd0, 5'd0, 6'd0);
    reset_b = 1'b1;
    step(SYSRESET);
    for (int i = 0; i < 10; i++) begin
      mem_if.act_rdata = 16'(i * 16'h1111);
      step(WAIT);
    end
    chk_idle("wait10", 8'd0, 5'd0, 6'd0);

    // Hand-computed frames.
    do_frame(16'hFFFF, 16'hFFFF, 5'd8,  5'd16, WD_ALL,  8'd0, "f_ones");
    for (int i = 0; i < 10; i++) step(WAIT);
    chk_idle("wait_hold", 8'd1, 5'd16, WD_ALL);
    do_frame(16'h00FF, 16'hFF00, 5'd1,  5'd0,  WD_NONE, 8'd1, "f_zero");
    do_frame(16'hA5A5, 16'hA5A4, 5'd15, 5'd15, WD_T15,  8'd2, "f_t15");
    do_frame(16'hA5A5, 16'hA5A4, 5'd16, 5'd15, WD_T16,  8'd3, "f_t16");

    // Out-of-order COUNT1S reuses the current XNOR word (FFFE -> 15).
    step(COUNT1S);
    chk("ooo.popcount", popcount, 5'd15);

    // Reset during COUNT1S of a frame: everything clears, no write.
    mem_if.act_rdata = 16'hFFFF;
    mem_if.wgt_rdata = 16'hFFFF;
    step(READMEM);
    step(XNORS);
    reset_b = 1'b0;
    cState  = COUNT1S;
    #1;
    chk("midrst.wr_en", mem_if.wr_en, 0);
    @(posedge clk);
    #1;
    chk_idle("midrst", 8'd0, 5'd0, 6'd0);
    reset_b = 1'b1;
    step(SYSRESET);
    step(WAIT);
    do_frame(16'hFFFF, 16'hFFFF, 5'd8, 5'd16, WD_ALL, 8'd0, "f_after");

    // SYSRESET alone clears pointers and data.
    step(SYSRESET);
    chk_idle("sysrst", 8'd0, 5'd0, 6'd0);
    step(WAIT);

    // 257 frames: frame 256 uses address 255, frame 257 wraps to 0.
    for (int k = 0; k < 257; k++) begin
      do_frame(16'hFFFF, 16'hFFFF, 5'd8, 5'd16, WD_ALL, 8'(k), "wrap");
    end
    chk_idle("wrap_end", 8'd1, 5'd16, WD_ALL);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/binconv_datapath.md
# binconv_datapath

Datapath slave of the binary-convolution controller. It decodes the controller's 3-bit `cState` each cycle and performs one step per state: fetch an activation/weight word pair, XNOR them, popcount the result, threshold it, and write the result to output memory. It sits directly downstream of the controller and owns the read/write address pointers and all intermediate result registers.

## Interface
Parameters:
- `N`, 16: activation/weight word width in bits (power of two, ≥4).
- `DEPTH`, 256: number of entries in the input and output memories (power of two).
- `AW`, `$clog2(DEPTH)`: address width.
- `CW`, `$clog2(N+1)`: popcount width.
- `OW`, `$clog2(N)+2`: result word width (holds signed −N..+N).

Ports:
- `clk` in 1: the single clock; all registers update on the rising edge.
- `reset_b` in 1: reset is synchronous and active-low.
- `cState` in 3: controller state (WAIT 000, READMEM 001, XNORS 011, COUNT1S 010, OUTPUTS 110, WRITEMEM 111, DONE 101, SYSRESET 100).
- `thresh` in CW: popcount threshold, sampled in OUTPUTS.
- `rd_addr` out AW: input-memory read address; registered value of `rd_ptr`.
- `rd_en` out 1: combinational, high iff `cState`==READMEM.
- `act_rdata` in N: activation word; combinational-read memory; valid in the same cycle as `rd_en`.
- `wgt_rdata` in N: weight word; same timing as `act_rdata`.
- `wr_addr` out AW: output-memory write address; registered value of `wr_ptr`.
- `wr_en` out 1: combinational, high iff `cState`==WRITEMEM.
- `wr_data` out OW: registered result word.
- `done` out 1: combinational, high iff `cState`==DONE.
- `popcount` out CW: registered popcount, for debug and scoreboard.

## Operation
- Each state's action is committed at the rising edge that ends a cycle in which `cState` holds that state.
- READMEM: `act_r <= act_rdata`, `wgt_r <= wgt_rdata`.
- XNORS: `xnor_r <= ~(act_r ^ wgt_r)`.
- COUNT1S: `popcount <= number of 1s in xnor_r` (0..N, CW bits, no overflow).
- OUTPUTS: `wr_data` is loaded per Configuration.
- WRITEMEM: `wr_en`=1 for exactly this cycle; then `wr_ptr <= wr_ptr+1`, wrapping DEPTH−1→0.
- DONE: `done`=1 for this cycle; then `rd_ptr <= rd_ptr+1`, wrapping DEPTH−1→0.
- WAIT: all registers hold.
- SYSRESET: clears `rd_ptr`, `wr_ptr`, `act_r`, `wgt_r`, `xnor_r`, `popcount` and `wr_data` to 0, identical to `reset_b`=0.
- Out-of-order states (e.g. COUNT1S without a preceding XNORS) are not errors. The state's action runs on the current register contents.
- Any undefined code cannot occur. All 8 codes are defined.
- Pointers run independently. After reset they stay equal as long as every frame passes through WRITEMEM and DONE.

## Timing
- Reset: when `reset_b`=0 at an edge, all registers go to 0. `rd_en`, `wr_en` and `done` follow `cState` combinationally; the controller drives SYSRESET during reset, so they read 0.
- Latency: operands are captured at the end of READMEM. `wr_data` is valid from the cycle after OUTPUTS, i.e. throughout WRITEMEM. That is 4 edges from operand capture to write.
- Reset mid-frame: partial results are discarded, pointers return to 0, and no write occurs.
- `thresh` only needs to be stable during the OUTPUTS cycle.
- Pointer wrap: after a write at entry DEPTH−1, the next write goes to entry 0. There is no full or overflow flag.

## Configuration
- `BINCONV_SIGNED_OUT_EN` defined: OUTPUTS loads `wr_data <= 2*popcount − N` as a two's-complement OW-bit value (the ±1 dot product). `thresh` is ignored.
- `BINCONV_SIGNED_OUT_EN` undefined: OUTPUTS loads `wr_data <= {OW-1 zeros, (popcount >= thresh)}`.

## Test plan
- Reset, then SYSRESET→WAIT: all outputs 0, `rd_addr`=`wr_addr`=0. Hold WAIT for 10 cycles: nothing changes.
- N=16, act=16'hFFFF, wgt=16'hFFFF, thresh=8, full sequence: `popcount`=16; `wr_data`=1 (macro off) or 6'd16 (macro on); `wr_en` is high one cycle at address 0; `done` is high one cycle; afterwards `rd_addr`=`wr_addr`=1.
- act=16'h00FF, wgt=16'hFF00, thresh=1: `popcount`=0; `wr_data`=0 (off) or 6'b110000 = −16 (on).
- act=16'hA5A5, wgt=16'hA5A4, thresh=15: `popcount`=15; `wr_data`=1 (off) or +14 (on). Repeat with thresh=16: `wr_data`=0 (off).
- Run 257 frames with DEPTH=256: frame 256 writes address 255, frame 257 writes address 0, and `rd_addr` wraps the same way.
- Assert `reset_b`=0 during COUNT1S of frame 3: registers clear, no `wr_en` pulse, the next frame reads and writes address 0.
